lcm_dispatch: RTL and testbench

LCM_DISPATCH -- requirements
Module: lcm_dispatch

---
 rtl/lcm_pkg.sv | 14 +
 rtl/lcm_op_fifo.sv | 56 +++++
 rtl/lcm_dispatch.sv | 128 ++++++++++++
 tb/tb_lcm_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_pkg.sv
// Shared types and default constants for the LCM dispatcher and LCM core.
package lcm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } lcm_state_e;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/lcm_op_fifo.sv
// Operand-pair FIFO; wrap-around pointers carry an extra MSB for full/empty.
module lcm_op_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + ONE;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcm_dispatch.sv
// Buffers operand pairs and issues them one at a time to the LCM core.
// Optional LCM_ZERO_GUARD_EN drops pairs with a zero operand and flags err_zero.
module lcm_dispatch
    import lcm_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_a,
    input  logic [DATA_WIDTH-1:0]         in_b,
    output logic                          in_ready,
    output logic                          lcm_en,
    output logic [DATA_WIDTH-1:0]         lcm_a,
    output logic [DATA_WIDTH-1:0]         lcm_b,
    input  logic                          lcm_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef LCM_ZERO_GUARD_EN
    output logic                          err_zero,
`endif
    output logic                          err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    lcm_state_e              state;
    logic [CW-1:0]           cnt;
    logic [2*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]   head_a;
    logic [DATA_WIDTH-1:0]   head_b;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    launch_ok;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign pop      = (state == IDLE) && !fifo_empty;
    assign head_a   = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_b   = head[DATA_WIDTH-1:0];

`ifdef LCM_ZERO_GUARD_EN
    assign launch_ok = !fifo_empty && (head_a != '0) && (head_b != '0);

    // A zero-operand head is still popped, just never launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_zero <= 1'b0;
        else
            err_zero <= pop && !launch_ok;
    end
`else
    assign launch_ok = !fifo_empty;
`endif

    lcm_op_fifo #(
        .W     (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lcm_en      <= 1'b0;
            lcm_a       <= '0;
            lcm_b       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            lcm_en      <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (state == IDLE && launch_ok) begin
                        lcm_a  <= head_a;
                        lcm_b  <= head_b;
                        lcm_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result in the limit cycle wins over the timeout.
                    if (lcm_valid) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_dispatch.sv
// Directed bench for lcm_dispatch; define LCM_ZERO_GUARD_EN to cover the zero guard.
module tb_lcm_dispatch;
    import lcm_pkg::*;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          lcm_valid = 1'b0;
    logic          in_ready;
    logic          lcm_en;
    logic [DW-1:0] lcm_a;
    logic [DW-1:0] lcm_b;
    logic          busy;
    logic [2:0]    fifo_level;
    logic          err_timeout;
`ifdef LCM_ZERO_GUARD_EN
    logic          err_zero;
`endif

    lcm_dispatch #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .lcm_en      (lcm_en),
        .lcm_a       (lcm_a),
        .lcm_b       (lcm_b),
        .lcm_valid   (lcm_valid),
        .busy        (busy),
        .fifo_level  (fifo_level),
`ifdef LCM_ZERO_GUARD_EN
        .err_zero    (err_zero),
`endif
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        bit            pre;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        bit hold;
        push(v.a, v.b);
        chk("pre_launch_en", lcm_en, 0);
        step();
        chk("launch_en", lcm_en, 1);
        chk("launch_a", lcm_a, v.ea);
        chk("launch_b", lcm_b, v.eb);
        chk("launch_busy", busy, 1);
        if (v.pre) lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
        chk("single_pulse", lcm_en, 0);
        chk("wait_busy", busy, 1);
        hold = 1'b1;
        for (int i = 0; i < v.lat; i++) begin
            if (lcm_a != v.ea || lcm_b != v.eb || !busy || lcm_en) hold = 1'b0;
            step();
        end
        chk("operand_hold", hold, 1);
        lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
        chk("done_busy", busy, 0);
        chk("done_err", err_timeout, 0);
        chk("done_en", lcm_en, 0);
    endtask

    initial begin
        int cl;
        int n;
        int seen;
        bit ok;

        tbl[0] = '{a: 8'd40,  b: 8'd25,  lat: 5,  pre: 1'b0, ea: 8'd40,  eb: 8'd25};
        tbl[1] = '{a: 8'd255, b: 8'd1,   lat: 0,  pre: 1'b1, ea: 8'd255, eb: 8'd1};
        tbl[2] = '{a: 8'd128, b: 8'd255, lat: 2,  pre: 1'b1, ea: 8'd128, eb: 8'd255};
        tbl[3] = '{a: 8'd7,   b: 8'd9,   lat: 10, pre: 1'b0, ea: 8'd7,   eb: 8'd9};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", lcm_en, 0);
        chk("rst_a", lcm_a, 0);
        chk("rst_b", lcm_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) do_op(tbl[i]);

        // Keep the FSM parked in WAIT so nothing pops while filling.
        push(8'd1, 8'd2);
        step();
        chk("bb_launch", lcm_en, 1);
        cl = cyc;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = DW'(10 + i);
            in_b = DW'(20 + i);
            chk("bb_in_ready", in_ready, (i < 4) ? 1 : 0);
            step();
        end
        chk("bb_level", fifo_level, 4);
        chk("bb_held_off", in_ready, 0);
        in_valid = 1'b0;

        n = 0;
        while (!err_timeout && n < 300) begin
            step();
            n++;
        end
        chk("to_seen", err_timeout, 1);
        chk("to_wait_cycles", cyc - cl - 1, TO);
        chk("to_level", fifo_level, 4);
        step();
        chk("to_pulse", err_timeout, 0);
        chk("next_en", lcm_en, 1);
        chk("next_a", lcm_a, 10);
        chk("next_b", lcm_b, 20);
        chk("next_level", fifo_level, 3);

        step();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", lcm_en, 0);
        chk("mid_rst_a", lcm_a, 0);
        chk("mid_rst_b", lcm_b, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_err", err_timeout, 0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            step();
            if (lcm_en || busy) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        chk("post_rst_level", fifo_level, 0);

        push(8'd5, 8'd6);
        step();
        chk("lim_launch", lcm_en, 1);
        step();
        ok = 1'b1;
        repeat (TO - 1) begin
            if (err_timeout || !busy) ok = 1'b0;
            step();
        end
        lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
        chk("lim_no_early", ok, 1);
        chk("lim_err", err_timeout, 0);
        chk("lim_busy", busy, 0);
        step();
        chk("lim_err_after", err_timeout, 0);

        push(8'd0, 8'd7);
        push(8'd12, 8'd18);
`ifdef LCM_ZERO_GUARD_EN
        chk("zg_err_zero", err_zero, 1);
        chk("zg_no_en", lcm_en, 0);
        step();
        chk("zg_pulse", err_zero, 0);
        chk("zg_en", lcm_en, 1);
        chk("zg_a", lcm_a, 12);
        chk("zg_b", lcm_b, 18);
        step();
        lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
`else
        chk("z_en", lcm_en, 1);
        chk("z_a", lcm_a, 0);
        chk("z_b", lcm_b, 7);
        step();
        lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
        step();
        chk("z2_en", lcm_en, 1);
        chk("z2_a", lcm_a, 12);
        chk("z2_b", lcm_b, 18);
        step();
        lcm_valid = 1'b1;
        step();
        lcm_valid = 1'b0;
`endif
        chk("end_busy", busy, 0);
        chk("end_level", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
